// File: rtl/matmul_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_ctrl
//
// Sequences one square matrix multiply C = A * B over three single-port
// BRAMs. The operands are unsigned and stored row-major from address 0.
// Each result element takes DIM multiply-accumulate cycles followed by one
// write cycle. A one-cycle done pulse follows the last write.
//
// Ports
//   clock        in   single clock, rising-edge state updates
//   reset        in   synchronous active-low reset
//   start        in   begin one multiply (only looked at in IDLE)
//   busy         out  high in MAC and WRITE
//   done         out  one-cycle completion pulse (DONE state)
//   a_rd_addr    out  registered read address, operand BRAM A
//   b_rd_addr    out  registered read address, operand BRAM B
//   a_dout       in   operand A read data
//   b_dout       in   operand B read data
//   c_wr_en      out  result BRAM write enable (WRITE state only)
//   c_wr_addr    out  result BRAM write address
//   c_din        out  result BRAM write data (accumulator)
//   o_dbg_state  out  current FSM state encoding, for checkers
//
// Handshake: start is a level sampled at each rising edge while in IDLE.
// It is not acknowledged; busy rising on the following cycle shows that it
// was taken. Requests made outside IDLE are dropped, not queued.
// ---------------------------------------------------------------------------
module matmul_ctrl #(
    parameter int DIM        = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(DIM)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] a_rd_addr,
    output logic [ADDR_WIDTH-1:0] b_rd_addr,
    input  logic [DATA_WIDTH-1:0] a_dout,
    input  logic [DATA_WIDTH-1:0] b_dout,
    output logic                  c_wr_en,
    output logic [ADDR_WIDTH-1:0] c_wr_addr,
    output logic [ACC_WIDTH-1:0]  c_din,
    output logic [1:0]            o_dbg_state
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_i;
    logic [CW-1:0]         r_j;
    logic [CW-1:0]         r_k;
    logic [CW-1:0]         w_i_nxt;
    logic [CW-1:0]         w_j_nxt;
    logic [CW-1:0]         w_k_nxt;
    logic [ADDR_WIDTH-1:0] r_a_addr;
    logic [ADDR_WIDTH-1:0] r_b_addr;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ACC_WIDTH-1:0]  w_prod;

    // Row-major linear address of element (row, col).
    function automatic logic [ADDR_WIDTH-1:0] lin_addr(
        input logic [CW-1:0] row,
        input logic [CW-1:0] col
    );
        return ADDR_WIDTH'(row) * ADDR_WIDTH'(DIM) + ADDR_WIDTH'(col);
    endfunction

    // Both operands are widened before the multiply so the product is
    // carried at full accumulator width.
    assign w_prod = ACC_WIDTH'(a_dout) * ACC_WIDTH'(b_dout);

    // Next-state and next-index logic.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_MAC;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                end
            end
            S_MAC: begin
                if (r_k == LAST) begin
                    w_state_nxt = S_WRITE;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_WRITE: begin
                if (r_j == LAST) begin
                    w_j_nxt = '0;
                    if (r_i == LAST) begin
                        w_i_nxt     = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_i_nxt     = r_i + 1'b1;
                        w_state_nxt = S_MAC;
                    end
                end else begin
                    w_j_nxt     = r_j + 1'b1;
                    w_state_nxt = S_MAC;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, index, accumulator and read-address registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_a_addr <= '0;
            r_b_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            // The BRAM returns data for the address presented in the same
            // cycle, so the product here belongs to the current (i,j,k).
            if (r_state == S_MAC) begin
                if (r_k == '0) begin
                    r_acc <= w_prod;
                end else begin
                    r_acc <= r_acc + w_prod;
                end
            end
            // Addresses are loaded one edge ahead, from the indices of the
            // MAC cycle about to start; outside MAC they hold.
            if (w_state_nxt == S_MAC) begin
                r_a_addr <= lin_addr(w_i_nxt, w_k_nxt);
                r_b_addr <= lin_addr(w_k_nxt, w_j_nxt);
            end
        end
    end

    assign busy        = (r_state == S_MAC) || (r_state == S_WRITE);
    assign done        = (r_state == S_DONE);
    // Gated by reset so that a reset arriving during WRITE suppresses the
    // write at that same edge.
    assign c_wr_en     = (r_state == S_WRITE) && reset;
    assign c_wr_addr   = lin_addr(r_i, r_j);
    assign c_din       = r_acc;
    assign a_rd_addr   = r_a_addr;
    assign b_rd_addr   = r_b_addr;
    assign o_dbg_state = r_state;

endmodule
